// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, operands shifted LSB first over WIDTH clocks.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port that selects a - b.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-1:0] r_shS;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_bLoad;
  logic             w_cLoad;
  logic             w_half1;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_shSNext;

  // Subtraction is a + ~b + 1, so only the B operand and the carry seed change.
  always_comb begin
    w_bLoad = b;
    w_cLoad = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      w_bLoad = ~b;
      w_cLoad = 1'b1;
    end
`endif
  end

  assign w_half1   = r_shA[0] ^ r_shB[0];
  assign w_s       = w_half1 ^ r_carry;
  assign w_c       = (r_shA[0] & r_shB[0]) | (r_carry & w_half1);
  assign w_shSNext = {w_s, r_shS[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shA   <= '0;
      r_shB   <= '0;
      r_shS   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_shA   <= r_shA >> 1;
          r_shB   <= r_shB >> 1;
          r_shS   <= w_shSNext;
          r_carry <= w_c;
          // Results are published only on the last bit so sum never shows partial values.
          if (r_cnt == LAST) begin
            sum     <= w_shSNext;
            cout    <= w_c;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_shA   <= a;
            r_shB   <= w_bLoad;
            r_carry <= w_cLoad;
            r_shS   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, multi-cycle corner cases, random ops.
// Honours SERIAL_ADDER_SUB_EN when the design is built with subtraction.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] lastSum;
  logic         lastCout;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         backToBack;
    logic [W-1:0] expSum;
    logic         expCout;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W:0] refAdd(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic s);
    int unsigned total;
    logic [W:0]  r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      total = int'(x) + int'(y) + int'(ci);
      r     = total[W:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one start pulse from the current (off-edge) time; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci, input logic s);
    a   = x;
    b   = y;
    cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`else
    if (s) $display("[TB] note: sub request ignored in add-only build");
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    checkOutput("sumHeldAtStart", 32'(sum), 32'(lastSum));
  endtask

  task automatic waitResult(input string name, input logic [W-1:0] eSum, input logic eCout,
                            input int injectAt);
    int  k;
    bit  seen;
    seen = 1'b0;
    for (k = 1; k <= W + 3; k++) begin
      if (k == injectAt) begin
        a     = ~a;
        b     = ~b;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      checkOutput({name, "_sumHeld"}, 32'(sum), 32'(lastSum));
      checkOutput({name, "_coutHeld"}, 32'(cout), 32'(lastCout));
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got no done expected done within %0d cycles", name, W + 3);
    end else begin
      checkOutput({name, "_latency"}, 32'(k), 32'(W));
      checkOutput({name, "_sum"}, 32'(sum), 32'(eSum));
      checkOutput({name, "_cout"}, 32'(cout), 32'(eCout));
      checkOutput({name, "_busyLow"}, 32'(busy), 32'd0);
    end
    lastSum  = eSum;
    lastCout = eCout;
  endtask

  task automatic afterDone(input string name);
    @(posedge clk);
    #1;
    checkOutput({name, "_doneDrop"}, 32'(done), 32'd0);
    checkOutput({name, "_idleBusy"}, 32'(busy), 32'd0);
    checkOutput({name, "_sumKept"}, 32'(sum), 32'(lastSum));
  endtask

  task automatic addVec(input string n, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s, input logic b2b,
                        input logic [W-1:0] es, input logic ec);
    vec_t v;
    v.name = n; v.a = x; v.b = y; v.cin = ci; v.sub = s;
    v.backToBack = b2b; v.expSum = es; v.expCout = ec;
    vecs.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rc;
    logic         rs;
    logic [W:0]   r;

    addVec("add3C0F",   8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h4B, 1'b0);
    addVec("addFF01",   8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    addVec("b2b7F80",   8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
    addVec("addAA55c",  8'hAA, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    addVec("add0000c",  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
    addVec("addFFFFc",  8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
    addVec("sub1001",   8'h10, 8'h01, 1'b0, 1'b1, 1'b0, 8'h0F, 1'b1);
    addVec("sub0102",   8'h01, 8'h02, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    addVec("sub5555",   8'h55, 8'h55, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
`endif

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    lastSum  = '0;
    lastCout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("resetSum", 32'(sum), 32'h0);
      checkOutput("resetCout", 32'(cout), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      waitResult(vecs[i].name, vecs[i].expSum, vecs[i].expCout, 0);
      if (i + 1 == vecs.size() || !vecs[i+1].backToBack) afterDone(vecs[i].name);
    end

    // A start during RUN must be dropped and the original operands completed.
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
    waitResult("ignoredStart", 8'h46, 1'b0, 3);
    afterDone("ignoredStart");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("ignoredStartNoSecondDone", 32'(done), 32'd0);
      checkOutput("ignoredStartNoRestart", 32'(busy), 32'd0);
    end

    // Reset on the fourth RUN edge aborts with no done pulse.
    applyStimulus(8'h55, 8'h66, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abortSum", 32'(sum), 32'h0);
    checkOutput("abortCout", 32'(cout), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    lastSum  = '0;
    lastCout = 1'b0;
    for (int i = 0; i < W + 1; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abortNoDone", 32'(done), 32'd0);
    end
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
    waitResult("afterAbort", 8'h02, 1'b0, 0);
    afterDone("afterAbort");

    for (int i = 0; i < 24; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      r = refAdd(rx, ry, rc, rs);
      applyStimulus(rx, ry, rc, rs);
      waitResult("random", r[W-1:0], r[W], 0);
      if ($urandom_range(0, 1) == 1) afterDone("random");
    end
    afterDone("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
